writeback_unit: RTL and testbench

- Final pipeline stage of MinCPU; feeds the write port (rd_addr/rd_data/reg_we) of the 32x32 register file.
- Merges two result sources: single-cycle ALU results and load responses from the data-memory interface.
- Loads have priority. A one-entry ALU skid buffer absorbs collisions.
- Formats load data (byte/half/word, signed/unsigned) and exposes forwarding/hazard info to decode.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/writeback_unit_load_formatter.sv | 51 +++++
 rtl/writeback_unit.sv | 147 ++++++++++++++
 tb/tb_writeback_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the MinCPU writeback stage: load funct3 codes,
// result-source select encoding and streak counter sizing.
package wb_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam int STREAK_W = 4;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_LD   = 2'd1,
      SEL_SKID = 2'd2,
      SEL_ALU  = 2'd3
   } sel_t;

endpackage

// File: rtl/writeback_unit_load_formatter.sv
// Combinational load formatter: lane extraction, sign/zero extension and
// detection of illegal funct3 codes or misaligned accesses.
module load_formatter
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]            funct3,
   input  logic [1:0]            addr_lo,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  err
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata[7:0];
      case (addr_lo)
         2'd0:    byte_lane = rdata[7:0];
         2'd1:    byte_lane = rdata[15:8];
         2'd2:    byte_lane = rdata[23:16];
         default: byte_lane = rdata[31:24];
      endcase
      half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      data = '0;
      err  = 1'b0;
      case (funct3)
         F3_LB:  data = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
         F3_LBU: data = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
         F3_LH: begin
            data = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
            err  = addr_lo[0];
         end
         F3_LHU: begin
            data = {{(DATA_WIDTH-16){1'b0}}, half_lane};
            err  = addr_lo[0];
         end
         F3_LW: begin
            data = rdata;
            err  = (addr_lo != 2'd0);
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/writeback_unit.sv
// MinCPU writeback stage: merges ALU results and load responses (loads first)
// through a one-entry ALU skid. Optional retire counter: WB_RETIRE_CNT_EN.
module writeback_unit
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 5,
   parameter int MAX_LD_STREAK = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [ADDR_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0] alu_data,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [ADDR_WIDTH-1:0] ld_rd,
   input  logic [2:0]            ld_funct3,
   input  logic [1:0]            ld_addr_lo,
   input  logic [DATA_WIDTH-1:0] ld_rdata,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  reg_we,
   output logic                  skid_valid,
   output logic [ADDR_WIDTH-1:0] skid_rd,
   output logic                  ld_err,
   output logic [31:0]           retire_cnt
);

   logic                  skid_valid_reg, skid_valid_next;
   logic [ADDR_WIDTH-1:0] skid_rd_reg, skid_rd_next;
   logic [DATA_WIDTH-1:0] skid_data_reg, skid_data_next;
   logic [STREAK_W-1:0]   streak_reg, streak_next;
   logic [ADDR_WIDTH-1:0] rd_addr_reg;
   logic [DATA_WIDTH-1:0] rd_data_reg;
   logic                  reg_we_reg;
   logic                  ld_err_reg;

   logic                  ld_acc, alu_acc;
   sel_t                  sel;
   logic [ADDR_WIDTH-1:0] sel_rd;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [DATA_WIDTH-1:0] fmt_data;
   logic                  fmt_err;

   load_formatter #(.DATA_WIDTH(DATA_WIDTH)) u_fmt (
      .funct3  (ld_funct3),
      .addr_lo (ld_addr_lo),
      .rdata   (ld_rdata),
      .data    (fmt_data),
      .err     (fmt_err)
   );

   // Handshakes depend only on registered state so upstream sees no loops.
   assign alu_ready = !skid_valid_reg;
   assign ld_ready  = (streak_reg != STREAK_W'(MAX_LD_STREAK));
   assign ld_acc    = ld_valid && ld_ready;
   assign alu_acc   = alu_valid && alu_ready;

   always_comb begin
      sel      = SEL_NONE;
      sel_rd   = '0;
      sel_data = '0;
      if (ld_acc) begin
         sel      = SEL_LD;
         sel_rd   = ld_rd;
         sel_data = fmt_data;
      end else if (skid_valid_reg) begin
         sel      = SEL_SKID;
         sel_rd   = skid_rd_reg;
         sel_data = skid_data_reg;
      end else if (alu_acc) begin
         sel      = SEL_ALU;
         sel_rd   = alu_rd;
         sel_data = alu_data;
      end
   end

   always_comb begin
      skid_valid_next = skid_valid_reg;
      skid_rd_next    = skid_rd_reg;
      skid_data_next  = skid_data_reg;
      if (sel == SEL_SKID) begin
         skid_valid_next = 1'b0;
      end else if (alu_acc && sel != SEL_ALU) begin
         skid_valid_next = 1'b1;
         skid_rd_next    = alu_rd;
         skid_data_next  = alu_data;
      end

      streak_next = '0;
      if (skid_valid_reg && sel == SEL_LD)
         streak_next = streak_reg + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         skid_valid_reg <= 1'b0;
         skid_rd_reg    <= '0;
         skid_data_reg  <= '0;
         streak_reg     <= '0;
         rd_addr_reg    <= '0;
         rd_data_reg    <= '0;
         reg_we_reg     <= 1'b0;
         ld_err_reg     <= 1'b0;
      end else begin
         skid_valid_reg <= skid_valid_next;
         skid_rd_reg    <= skid_rd_next;
         skid_data_reg  <= skid_data_next;
         streak_reg     <= streak_next;
         reg_we_reg     <= 1'b0;
         ld_err_reg     <= 1'b0;
         // Errored loads are consumed but leave the forwarding bus untouched.
         if (sel == SEL_LD && fmt_err) begin
            ld_err_reg <= 1'b1;
         end else if (sel != SEL_NONE) begin
            rd_addr_reg <= sel_rd;
            rd_data_reg <= sel_data;
            reg_we_reg  <= (sel_rd != '0);
         end
      end
   end

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst)
         retire_cnt_reg <= '0;
      else if (sel != SEL_NONE)
         retire_cnt_reg <= retire_cnt_reg + 32'd1;
   end

   assign retire_cnt = retire_cnt_reg;
`else
   assign retire_cnt = '0;
`endif

   assign rd_addr    = rd_addr_reg;
   assign rd_data    = rd_data_reg;
   assign reg_we     = reg_we_reg;
   assign skid_valid = skid_valid_reg;
   assign skid_rd    = skid_rd_reg;
   assign ld_err     = ld_err_reg;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit.
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [2:0]  ld_funct3;
   logic [1:0]  ld_addr_lo;
   logic [31:0] ld_rdata;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        reg_we;
   logic        skid_valid;
   logic [4:0]  skid_rd;
   logic        ld_err;
   logic [31:0] retire_cnt;

   int checks = 0;
   int errors = 0;
   int exp_retire = 0;

   always #5 clk = ~clk;

   writeback_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .MAX_LD_STREAK(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_rd      (ld_rd),
      .ld_funct3  (ld_funct3),
      .ld_addr_lo (ld_addr_lo),
      .ld_rdata   (ld_rdata),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .reg_we     (reg_we),
      .skid_valid (skid_valid),
      .skid_rd    (skid_rd),
      .ld_err     (ld_err),
      .retire_cnt (retire_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_retire(input string tag);
`ifdef WB_RETIRE_CNT_EN
      check(tag, retire_cnt, exp_retire);
`else
      check(tag, retire_cnt, 32'd0);
`endif
   endtask

   task automatic set_ld(input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] lo, input logic [31:0] d);
      ld_valid   = 1'b1;
      ld_rd      = rd;
      ld_funct3  = f3;
      ld_addr_lo = lo;
      ld_rdata   = d;
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [1:0]  lo;
      logic [4:0]  rd;
      logic [31:0] exp;
   } fmt_vec_t;

   fmt_vec_t fmt_tab[4];

   initial begin
      fmt_tab[0] = '{3'b000, 2'd2, 5'd6, 32'hFFFF_FFFF};
      fmt_tab[1] = '{3'b100, 2'd3, 5'd7, 32'h0000_0080};
      fmt_tab[2] = '{3'b001, 2'd2, 5'd8, 32'hFFFF_80FF};
      fmt_tab[3] = '{3'b101, 2'd0, 5'd9, 32'h0000_7F01};

      rst = 1'b1;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      ld_valid = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_addr_lo = '0; ld_rdata = '0;
      step();
      step();
      rst = 1'b0;
      check("reset rd_addr", 32'(rd_addr), 32'd0);
      check("reset rd_data", rd_data, 32'd0);
      check("reset reg_we", 32'(reg_we), 32'd0);
      check("reset skid_valid", 32'(skid_valid), 32'd0);
      check("reset ld_err", 32'(ld_err), 32'd0);
      check("reset alu_ready", 32'(alu_ready), 32'd1);
      check("reset ld_ready", 32'(ld_ready), 32'd1);
      check_retire("reset retire_cnt");

      // ALU only
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
      step();
      alu_valid = 1'b0;
      exp_retire++;
      check("alu reg_we", 32'(reg_we), 32'd1);
      check("alu rd_addr", 32'(rd_addr), 32'd5);
      check("alu rd_data", rd_data, 32'h1234);
      check("alu alu_ready", 32'(alu_ready), 32'd1);

      // Collision: load wins, ALU parks in skid
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAAAA;
      set_ld(5'd4, 3'b010, 2'd0, 32'h55AA_55AA);
      step();
      alu_valid = 1'b0; ld_valid = 1'b0;
      exp_retire++;
      check("coll ld rd_addr", 32'(rd_addr), 32'd4);
      check("coll ld rd_data", rd_data, 32'h55AA_55AA);
      check("coll ld reg_we", 32'(reg_we), 32'd1);
      check("coll skid_valid", 32'(skid_valid), 32'd1);
      check("coll skid_rd", 32'(skid_rd), 32'd3);
      check("coll alu_ready", 32'(alu_ready), 32'd0);
      step();
      exp_retire++;
      check("coll skid rd_addr", 32'(rd_addr), 32'd3);
      check("coll skid rd_data", rd_data, 32'hAAAA);
      check("coll skid reg_we", 32'(reg_we), 32'd1);
      check("coll skid drained", 32'(skid_valid), 32'd0);
      step();
      check("idle reg_we", 32'(reg_we), 32'd0);
      check("idle rd_addr hold", 32'(rd_addr), 32'd3);
      check("idle rd_data hold", rd_data, 32'hAAAA);

      // Load formats
      for (int i = 0; i < 4; i++) begin
         set_ld(fmt_tab[i].rd, fmt_tab[i].f3, fmt_tab[i].lo, 32'h80FF_7F01);
         step();
         exp_retire++;
         check($sformatf("fmt%0d rd_data", i), rd_data, fmt_tab[i].exp);
         check($sformatf("fmt%0d rd_addr", i), 32'(rd_addr), 32'(fmt_tab[i].rd));
         check($sformatf("fmt%0d reg_we", i), 32'(reg_we), 32'd1);
      end
      ld_valid = 1'b0;

      // Error loads: misaligned LW, then illegal funct3
      set_ld(5'd10, 3'b010, 2'd1, 32'hDEAD_BEEF);
      step();
      exp_retire++;
      check("err lw reg_we", 32'(reg_we), 32'd0);
      check("err lw ld_err", 32'(ld_err), 32'd1);
      check("err lw rd_data", rd_data, 32'h0000_7F01);
      set_ld(5'd11, 3'b011, 2'd0, 32'hDEAD_BEEF);
      step();
      ld_valid = 1'b0;
      exp_retire++;
      check("err f3 reg_we", 32'(reg_we), 32'd0);
      check("err f3 ld_err", 32'(ld_err), 32'd1);
      check("err f3 rd_data", rd_data, 32'h0000_7F01);
      step();
      check("err pulse end", 32'(ld_err), 32'd0);
      check_retire("retire after errors");

      // Starvation: skid full with continuous loads
      alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h0B;
      set_ld(5'd12, 3'b010, 2'd0, 32'hC0);
      step();
      alu_valid = 1'b0;
      exp_retire++;
      check("starv skid_valid", 32'(skid_valid), 32'd1);
      for (int k = 0; k < 4; k++) begin
         set_ld(5'(13 + k), 3'b010, 2'd0, 32'hD0 + 32'(k));
         check($sformatf("starv%0d ld_ready", k), 32'(ld_ready), 32'd1);
         step();
         exp_retire++;
         check($sformatf("starv%0d rd_addr", k), 32'(rd_addr), 32'(13 + k));
         check($sformatf("starv%0d rd_data", k), rd_data, 32'hD0 + 32'(k));
      end
      set_ld(5'd17, 3'b010, 2'd0, 32'hE0);
      check("starv ld_ready low", 32'(ld_ready), 32'd0);
      step();
      exp_retire++;
      check("starv skid rd_addr", 32'(rd_addr), 32'd11);
      check("starv skid rd_data", rd_data, 32'h0B);
      check("starv skid cleared", 32'(skid_valid), 32'd0);
      check("starv ld_ready back", 32'(ld_ready), 32'd1);
      step();
      ld_valid = 1'b0;
      exp_retire++;
      check("starv resume rd_addr", 32'(rd_addr), 32'd17);
      check("starv resume rd_data", rd_data, 32'hE0);
      check_retire("retire after starvation");

      // rd=0 is consumed without a write
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h77;
      step();
      alu_valid = 1'b0;
      exp_retire++;
      check("rd0 reg_we", 32'(reg_we), 32'd0);
      check_retire("rd0 retire_cnt");

      // Reset while skid holds an entry
      alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h99;
      set_ld(5'd21, 3'b010, 2'd0, 32'h21);
      step();
      alu_valid = 1'b0; ld_valid = 1'b0;
      check("rst pre skid_valid", 32'(skid_valid), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_retire = 0;
      check("rst rd_addr", 32'(rd_addr), 32'd0);
      check("rst rd_data", rd_data, 32'd0);
      check("rst reg_we", 32'(reg_we), 32'd0);
      check("rst skid_valid", 32'(skid_valid), 32'd0);
      check("rst skid_rd", 32'(skid_rd), 32'd0);
      check_retire("rst retire_cnt");
      step();
      check("rst no skid write", 32'(reg_we), 32'd0);
      check("rst rd_addr stays", 32'(rd_addr), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
